// File: rtl/dbg_inj.sv
// dbg_inj: logic-analyzer driven stimulus injector.
// The host loads samples one at a time over LA bits using a toggle/ack
// handshake. Samples are buffered in a small FIFO and replayed as a
// valid-qualified stream, one sample per rate tick.
//
// Optional feature: define DBG_INJ_STATS_EN to implement the overflow,
// underflow and sent-sample statistics. Without it those LA status bits
// read 0 and the underflow condition has no effect.
module dbg_inj #(
    parameter int DATA_BW = 8,
    parameter int DEPTH   = 16,
    parameter int RATE_BW = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [127:0]        la_data_in_i,
    input  logic [127:0]        la_oenb_i,
    output logic [127:0]        la_data_out_o,
    output logic [DATA_BW-1:0]  inj_data_o,
    output logic                inj_valid_o
);

    // FIFO pointer width and count width (count needs to reach DEPTH)
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    // The rate field starts at bit 18 and may not extend past bit 63
    localparam int RATE_HI = ((16 + RATE_BW) > 63) ? 63 : (16 + RATE_BW);

    // ------------------------------------------------------------------
    // LA input gating: every LA input reads 0 while the injector is off
    // ------------------------------------------------------------------
    logic [127:0] la_in;

    genvar gi;
    generate
        for (gi = 0; gi < 128; gi++) begin : g_la_gate
            assign la_in[gi] = la_data_in_i[gi] & la_oenb_i[0];
        end
    endgenerate

    // Field decode of the gated LA word
    logic               wr_toggle;
    logic [DATA_BW-1:0] wr_data;
    logic               play;
    logic               clear;
    logic [RATE_BW-1:0] rate_n;

    assign wr_toggle = la_in[0];
    assign wr_data   = la_in[DATA_BW:1];
    assign play      = la_in[16];
    assign clear     = la_in[17];
    assign rate_n    = RATE_BW'(la_in[RATE_HI:18]);

    // Bits of the LA bus that carry no function in this block
    logic unused_bits;
    assign unused_bits = ^{la_oenb_i[127:1], la_in};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               sync1_reg;
    logic               sync2_reg;
    logic               prev_reg;
    logic               ack_reg;
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic [RATE_BW-1:0] rc_reg;
    logic [DATA_BW-1:0] inj_data_reg;
    logic               inj_valid_reg;

    logic [DATA_BW-1:0] mem [DEPTH];

    // Status derived from the pre-edge occupancy
    logic full;
    logic empty;
    logic push;
    logic push_ok;
    logic tick;
    logic pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    // A toggle edge seen at the synchronizer output is one push request
    assign push    = sync2_reg ^ prev_reg;
    // Pushes are dropped while clearing or when the FIFO is already full
    assign push_ok = push & ~clear & ~full;
    // Rate tick: first cycle of play, then every N+1 cycles; never during clear
    assign tick    = play & ~clear & (rc_reg == '0);
    // A pop needs data already present before this edge
    assign pop     = tick & ~empty;

    // ------------------------------------------------------------------
    // Push path: toggle synchronizer, edge detect history and ack
    // ------------------------------------------------------------------
    // Synchronize the host toggle and echo each detected push on ack
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            ack_reg   <= 1'b0;
        end else begin
            sync1_reg <= wr_toggle;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (push) begin
                ack_reg <= ~ack_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    // Sample storage; wr_data is taken straight from the LA bus on the push edge
    always_ff @(posedge clk_i) begin
        if (rst_n_i && push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Occupancy update; simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Rate counter
    // ------------------------------------------------------------------
    // Reload with N on each tick, count down otherwise, idle at 0 when stopped
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rc_reg <= '0;
        end else if (!play || clear) begin
            rc_reg <= '0;
        end else if (rc_reg == '0) begin
            rc_reg <= rate_n;
        end else begin
            rc_reg <= rc_reg - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output stream
    // ------------------------------------------------------------------
    // Registered read of the head sample; data holds between strobes
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            inj_valid_reg <= 1'b0;
            inj_data_reg  <= '0;
        end else begin
            inj_valid_reg <= pop;
            if (pop) begin
                inj_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign inj_valid_o = inj_valid_reg;
    assign inj_data_o  = inj_data_reg;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
    logic        ovf_bit;
    logic        udf_bit;
    logic [15:0] sent_bits;

`ifdef DBG_INJ_STATS_EN
    logic        ovf_reg;
    logic        udf_reg;
    logic [15:0] sent_cnt_reg;

    // Sticky overflow/underflow flags and a wrapping count of emitted samples
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ovf_reg      <= 1'b0;
            udf_reg      <= 1'b0;
            sent_cnt_reg <= '0;
        end else if (clear) begin
            ovf_reg      <= 1'b0;
            udf_reg      <= 1'b0;
            sent_cnt_reg <= '0;
        end else begin
            if (push && full) begin
                ovf_reg <= 1'b1;
            end
            // Running dry only counts once something has been sent
            if (tick && empty && (sent_cnt_reg != 16'd0)) begin
                udf_reg <= 1'b1;
            end
            if (pop) begin
                sent_cnt_reg <= sent_cnt_reg + 16'd1;
            end
        end
    end

    assign ovf_bit   = ovf_reg;
    assign udf_bit   = udf_reg;
    assign sent_bits = sent_cnt_reg;
`else
    assign ovf_bit   = 1'b0;
    assign udf_bit   = 1'b0;
    assign sent_bits = 16'd0;
`endif

    // ------------------------------------------------------------------
    // LA status word
    // ------------------------------------------------------------------
    // Pack handshake, occupancy and statistics; unused bits read 0
    always_comb begin
        la_data_out_o        = '0;
        la_data_out_o[0]     = ack_reg;
        la_data_out_o[7:1]   = 7'(count_reg);
        la_data_out_o[8]     = full;
        la_data_out_o[9]     = empty;
        la_data_out_o[10]    = ovf_bit;
        la_data_out_o[11]    = udf_bit;
        la_data_out_o[27:12] = sent_bits;
    end

endmodule

// File: tb/tb_dbg_inj.sv
// Testbench for dbg_inj: directed scenarios plus a randomized host session,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_dbg_inj;

    localparam int DATA_BW = 8;
    localparam int DEPTH   = 16;
    localparam int RATE_BW = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [127:0]       la_data_in;
    logic [127:0]       la_oenb;
    logic [127:0]       la_data_out;
    logic [DATA_BW-1:0] inj_data;
    logic               inj_valid;

    always #5 clk = ~clk;

    // Host-side fields assembled into the LA words
    logic               en;
    logic               tog;
    logic               play;
    logic               clr;
    logic [DATA_BW-1:0] wdata;
    logic [14:0]        rate;
    logic [6:0]         junk_mid;
    logic [94:0]        junk_hi;
    logic [126:0]       oenb_junk;

    always_comb begin
        la_data_in            = '0;
        la_data_in[0]         = tog;
        la_data_in[DATA_BW:1] = wdata;
        la_data_in[15:9]      = junk_mid;
        la_data_in[16]        = play;
        la_data_in[17]        = clr;
        la_data_in[32:18]     = rate;
        la_data_in[127:33]    = junk_hi;
        la_oenb               = {oenb_junk, en};
    end

    dbg_inj #(
        .DATA_BW (DATA_BW),
        .DEPTH   (DEPTH),
        .RATE_BW (RATE_BW)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .la_data_in_i  (la_data_in),
        .la_oenb_i     (la_oenb),
        .la_data_out_o (la_data_out),
        .inj_data_o    (inj_data),
        .inj_valid_o   (inj_valid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [DATA_BW-1:0] m_fq[$];     // buffered samples, head first
    bit                 m_tq[$];     // toggle as sampled at the last three edges
    bit                 m_ack;
    bit                 m_ovf;
    bit                 m_udf;
    logic [15:0]        m_sent;
    int                 m_age;       // consecutive effective play cycles so far
    bit                 m_valid;
    logic [DATA_BW-1:0] m_data;

    logic [DATA_BW-1:0] seen_q[$];   // samples observed on the output stream

    task automatic model_reset();
        m_fq.delete();
        m_tq.delete();
        repeat (3) m_tq.push_back(1'b0);
        m_ack   = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_sent  = '0;
        m_age   = 0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // Advance model and DUT by one clock, then compare all outputs
    task automatic step();
        bit                 e_tog, e_play, e_clr, psh, tk, was_full, was_empty;
        logic [DATA_BW-1:0] e_data;
        int                 n;
        logic [127:0]       exp_out;

        junk_mid  = 7'($urandom);
        junk_hi   = {$urandom, $urandom, 31'($urandom)};
        oenb_junk = {$urandom, $urandom, $urandom, 31'($urandom)};

        e_tog  = en & tog;
        e_play = en & play;
        e_clr  = en & clr;
        e_data = en ? wdata : '0;
        n      = en ? int'(rate) : 0;

        if (!rst_n) begin
            model_reset();
        end else begin
            // A toggle change becomes a push two edges after it was sampled
            psh = (m_tq[1] != m_tq[0]);
            m_tq.push_back(e_tog);
            void'(m_tq.pop_front());
            was_full  = (m_fq.size() == DEPTH);
            was_empty = (m_fq.size() == 0);
            tk        = e_play && !e_clr && ((m_age % (n + 1)) == 0);
            m_valid   = 1'b0;
            if (psh) m_ack = ~m_ack;
            if (e_clr) begin
                m_fq.delete();
                m_ovf  = 1'b0;
                m_udf  = 1'b0;
                m_sent = '0;
            end else begin
                if (tk && !was_empty) begin
                    m_data  = m_fq.pop_front();
                    m_valid = 1'b1;
                    m_sent  = m_sent + 16'd1;
                end else if (tk && m_sent != 16'd0) begin
                    m_udf = 1'b1;
                end
                if (psh) begin
                    if (was_full) m_ovf = 1'b1;
                    else          m_fq.push_back(e_data);
                end
            end
            m_age = (e_play && !e_clr) ? m_age + 1 : 0;
        end

        @(posedge clk);
        #1;

        exp_out        = '0;
        exp_out[0]     = m_ack;
        exp_out[7:1]   = 7'(m_fq.size());
        exp_out[8]     = (m_fq.size() == DEPTH);
        exp_out[9]     = (m_fq.size() == 0);
`ifdef DBG_INJ_STATS_EN
        exp_out[10]    = m_ovf;
        exp_out[11]    = m_udf;
        exp_out[27:12] = m_sent;
`endif
        chk("la_out", la_data_out, exp_out);
        chk("inj_valid", 128'(inj_valid), 128'(m_valid));
        chk("inj_data", 128'(inj_data), 128'(m_data));
        if (inj_valid === 1'b1) begin
            seen_q.push_back(inj_data);
            $display("out  data=0x%02h sent=%0d ovf=%0b udf=%0b", inj_data, m_sent, m_ovf, m_udf);
        end
    endtask

    // Host write: toggle, hold data, expect the ack echo after three cycles
    task automatic host_push(input logic [DATA_BW-1:0] d);
        wdata = d;
        tog   = ~tog;
        $display("push data=0x%02h", d);
        for (int i = 0; i < 3; i++) step();
        chk("ack_echo", 128'(la_data_out[0]), 128'(tog));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tog   = 1'b0;
        step();
        rst_n = 1'b1;
        $display("reset");
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    logic [DATA_BW-1:0] exp_q[$];
    logic [DATA_BW-1:0] d;

    initial begin
        rst_n = 1'b0; en = 1'b0; tog = 1'b0; play = 1'b0; clr = 1'b0;
        wdata = '0; rate = '0; junk_mid = '0; junk_hi = '0; oenb_junk = '0;
        model_reset();

        // Reset state
        do_reset();
        step();
        chk("reset_out", la_data_out, 128'h200);
        chk("reset_valid", 128'(inj_valid), 128'd0);

        // Three samples replayed back to back at N=0
        en = 1'b1;
        host_push(8'h11);
        host_push(8'h22);
        host_push(8'h33);
        seen_q.delete();
        rate = 15'd0;
        play = 1'b1;
        for (int i = 0; i < 6; i++) step();
        play = 1'b0;
        chk("n0_count", 128'(seen_q.size()), 128'd3);
        if (seen_q.size() == 3) begin
            chk("n0_s0", 128'(seen_q[0]), 128'h11);
            chk("n0_s1", 128'(seen_q[1]), 128'h22);
            chk("n0_s2", 128'(seen_q[2]), 128'h33);
        end
`ifdef DBG_INJ_STATS_EN
        chk("n0_sent", 128'(la_data_out[27:12]), 128'd3);
`endif
        clear_pulse();

        // Overfill: 17 pushes into a 16-deep FIFO
        exp_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = DATA_BW'($urandom);
            if (i < DEPTH) exp_q.push_back(d);
            host_push(d);
        end
        chk("ovf_count", 128'(la_data_out[7:1]), 128'(DEPTH));
        chk("ovf_full", 128'(la_data_out[8]), 128'd1);
`ifdef DBG_INJ_STATS_EN
        chk("ovf_flag", 128'(la_data_out[10]), 128'd1);
`endif
        seen_q.delete();
        rate = 15'd1;
        play = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 6; i++) step();
        play = 1'b0;
        chk("ovf_replay_len", 128'(seen_q.size()), 128'(DEPTH));
        for (int i = 0; i < DEPTH && i < seen_q.size(); i++)
            chk("ovf_replay", 128'(seen_q[i]), 128'(exp_q[i]));
        clear_pulse();

        // Four samples at N=3, then underflow on the following tick
        for (int i = 0; i < 4; i++) host_push(DATA_BW'($urandom));
        seen_q.delete();
        rate = 15'd3;
        play = 1'b1;
        for (int i = 0; i < 20; i++) step();
        play = 1'b0;
        chk("n3_count", 128'(seen_q.size()), 128'd4);
`ifdef DBG_INJ_STATS_EN
        chk("n3_udf", 128'(la_data_out[11]), 128'd1);
`endif
        clear_pulse();

        // Clear while playing, with a push landing during clear
        for (int i = 0; i < 5; i++) host_push(DATA_BW'($urandom));
        rate = 15'd2;
        play = 1'b1;
        step();
        wdata = 8'hA5;
        tog   = ~tog;
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ack", 128'(la_data_out[0]), 128'(tog));
        chk("clr_status", 128'(la_data_out[27:1]), 128'h100);
        seen_q.delete();
        for (int i = 0; i < 8; i++) step();
        chk("clr_no_valid", 128'(seen_q.size()), 128'd0);
        play = 1'b0;

        // Reset in the middle of playout
        for (int i = 0; i < 4; i++) host_push(DATA_BW'($urandom));
        rate = 15'd1;
        play = 1'b1;
        step();
        step();
        do_reset();
        chk("rst_valid", 128'(inj_valid), 128'd0);
        chk("rst_out", la_data_out, 128'h200);
        play = 1'b0;
        step();

        // Randomized host session obeying the handshake rules
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    if (en) host_push(DATA_BW'($urandom));
                    else    step();
                end
                4: begin
                    if (!play) rate = 15'($urandom_range(0, 5));
                    play = ~play;
                    step();
                end
                5: clear_pulse();
                6: begin
                    if (en) begin
                        if (tog) host_push(DATA_BW'($urandom));
                        en = 1'b0;
                        step();
                    end else begin
                        en = 1'b1;
                        step();
                    end
                end
                7: begin
                    if ($urandom_range(0, 9) == 0) do_reset();
                    else step();
                end
                default: begin
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++) step();
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
